// File: rtl/uart_rx.sv
// 8N1 UART receiver: a 2-flop synchroniser, then a state machine that samples the middle of
// every bit, strobes each good byte for one cycle and flags a stop bit that samples low.
module uart_rx #(
   parameter int CLKS_PER_BIT = 1250,
   parameter int CNT_W        = 11
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       busy,
   output logic [3:0] bit_count
);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       shift, shift_n;
   logic [7:0]       data_n;
   logic [3:0]       bits_n;
   logic             valid_n, err_n;
   logic             rx_meta, rx_s;

   // Both synchroniser flops reset to 1 so that reset never looks like a start bit
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state     <= IDLE;
         cnt       <= '0;
         shift     <= '0;
         bit_count <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         shift     <= shift_n;
         bit_count <= bits_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         frame_err <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shift_n = shift;
      bits_n  = bit_count;
      data_n  = rx_data;
      valid_n = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) begin
               state_n = START;
               bits_n  = '0;
            end
         end
         // A line that is high again at mid-start was only a glitch
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n                   = '0;
               shift_n[bit_count[2:0]] = rx_s;
               bits_n                  = bit_count + 4'd1;
               if (bit_count == 4'd7) begin
                  state_n = STOP;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  data_n  = shift;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  err_n   = 1'b1;
                  state_n = WAIT_IDLE;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         // A held-low line (break) must return high before another frame is accepted
         WAIT_IDLE: begin
            cnt_n = '0;
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (16 clocks/bit) driven bit by bit, plus a
// default-rate instance fed in loopback from a small behavioural transmitter.
module tb_uart_rx;

   localparam int CPB   = 16;
   localparam int HALF  = CPB / 2;
   localparam int CPB_L = 1250;
   localparam int LAT   = 2 + HALF + 9 * CPB + 1;
   localparam int LAT_L = 2 + CPB_L / 2 + 9 * CPB_L + 1;

   logic       clk  = 1'b0;
   logic       nrst = 1'b1;
   logic       rx   = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, busy;
   logic [3:0] bit_count;

   logic [7:0] lb_data;
   logic       lb_valid, lb_err, lb_busy;
   logic [3:0] lb_bits;

   logic       tx_line  = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_byte  = 8'h00;
   logic [8:0] tx_shift = 9'h1FF;
   int         tx_cnt   = 0;
   int         tx_left  = 0;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int fall_cyc    = 0;

   int         valid_cnt = 0, err_cnt = 0, both_cnt = 0, valid_cyc = 0;
   logic [7:0] got [16];
   int         lb_valid_cnt = 0, lb_err_cnt = 0, lb_valid_cyc = 0;
   logic [7:0] lb_got = 8'h00;

   uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
      .clk(clk), .nrst(nrst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_err(frame_err), .busy(busy), .bit_count(bit_count)
   );

   uart_rx dut_lb (
      .clk(clk), .nrst(nrst), .rx(tx_line), .rx_data(lb_data), .rx_valid(lb_valid),
      .frame_err(lb_err), .busy(lb_busy), .bit_count(lb_bits)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmit stage for the loopback: start bit, 8 data bits LSB first, then idle-high stop
   always @(posedge clk) begin
      if (tx_start) begin
         tx_shift <= {1'b1, tx_byte};
         tx_line  <= 1'b0;
         tx_cnt   <= 0;
         tx_left  <= 9;
      end else if (tx_left != 0) begin
         if (tx_cnt == CPB_L - 1) begin
            tx_cnt   <= 0;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_left  <= tx_left - 1;
         end else begin
            tx_cnt <= tx_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rx_valid) begin
         got[valid_cnt % 16] <= rx_data;
         valid_cnt           <= valid_cnt + 1;
         valid_cyc           <= cyc;
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if ((rx_valid && frame_err) || (lb_valid && lb_err)) both_cnt <= both_cnt + 1;
      if (lb_valid) begin
         lb_got       <= lb_data;
         lb_valid_cnt <= lb_valid_cnt + 1;
         lb_valid_cyc <= cyc;
      end
      if (lb_err) lb_err_cnt <= lb_err_cnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called on a falling clock edge; drives one full frame, returns on a falling edge
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
      rx       = 1'b0;
      fall_cyc = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   int v0, e0;
   logic [7:0] c3 = 8'hC3;

   initial begin
      // Reset with a toggling line
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx = ~rx;
      end
      checkOutput("rst_data", rx_data, 8'h00);
      checkOutput("rst_valid", rx_valid, 1'b0);
      checkOutput("rst_err", frame_err, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_bits", bit_count, 4'd0);
      checkOutput("rst_lb_busy", lb_busy, 1'b0);
      rx   = 1'b1;
      nrst = 1'b0;
      repeat (4) @(negedge clk);

      // Single frame and its latency
      applyStimulus(8'hA5, 1'b1);
      checkOutput("single_cnt", valid_cnt, 1);
      checkOutput("single_data", got[0], 8'hA5);
      checkOutput("single_err", err_cnt, 0);
      checkOutput("single_latency", valid_cyc - fall_cyc, LAT);
      checkOutput("single_not_sticky", rx_valid, 1'b0);
      checkOutput("single_hold", rx_data, 8'hA5);
      checkOutput("single_idle", busy, 1'b0);

      // Back-to-back frames with no idle gap
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      applyStimulus(8'h3C, 1'b1);
      checkOutput("b2b_cnt", valid_cnt, 4);
      checkOutput("b2b_d0", got[1], 8'h00);
      checkOutput("b2b_d1", got[2], 8'hFF);
      checkOutput("b2b_d2", got[3], 8'h3C);
      checkOutput("b2b_err", err_cnt, 0);

      // Glitch shorter than half a bit
      repeat (CPB) @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      checkOutput("glitch_busy_hi", busy, 1'b1);
      for (int i = 0; i < HALF + 1 && busy; i++) @(negedge clk);
      checkOutput("glitch_busy_lo", busy, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      checkOutput("glitch_valid", valid_cnt, 4);
      checkOutput("glitch_err", err_cnt, 0);

      // Framing error followed by a break
      v0 = valid_cnt;
      e0 = err_cnt;
      applyStimulus(8'h55, 1'b0);
      repeat (100) @(negedge clk);
      checkOutput("ferr_cnt", err_cnt - e0, 1);
      checkOutput("ferr_valid", valid_cnt - v0, 0);
      checkOutput("ferr_hold", rx_data, 8'h3C);
      checkOutput("break_busy", busy, 1'b1);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
      checkOutput("break_release", busy, 1'b0);
      applyStimulus(8'h81, 1'b1);
      checkOutput("after_break_cnt", valid_cnt - v0, 1);
      checkOutput("after_break_data", got[v0 % 16], 8'h81);
      checkOutput("after_break_err", err_cnt - e0, 1);

      // Reset during bit 4 of 0xC3
      v0 = valid_cnt;
      e0 = err_cnt;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = c3[i];
         repeat (CPB) @(negedge clk);
      end
      rx = c3[4];
      repeat (4) @(negedge clk);
      checkOutput("mid_bits", bit_count, 4'd4);
      nrst = 1'b1;
      #1;
      checkOutput("mid_rst_data", rx_data, 8'h00);
      checkOutput("mid_rst_busy", busy, 1'b0);
      checkOutput("mid_rst_bits", bit_count, 4'd0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      nrst = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      checkOutput("mid_no_valid", valid_cnt - v0, 0);
      checkOutput("mid_no_err", err_cnt - e0, 0);
      applyStimulus(8'h12, 1'b1);
      checkOutput("post_rst_cnt", valid_cnt - v0, 1);
      checkOutput("post_rst_data", got[v0 % 16], 8'h12);

      // Loopback at the default bit rate
      tx_byte  = 8'hA5;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      fall_cyc = cyc;
      for (int i = 0; i < LAT_L + 2 * CPB_L && lb_valid_cnt == 0; i++) @(negedge clk);
      @(negedge clk);
      checkOutput("lb_cnt", lb_valid_cnt, 1);
      checkOutput("lb_data", lb_got, 8'hA5);
      checkOutput("lb_latency", lb_valid_cyc - fall_cyc, LAT_L);
      checkOutput("lb_err", lb_err_cnt, 0);

      checkOutput("no_overlap", both_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
